// File: rtl/uart_bus_responder_if.sv
// Parallel UART bus between uart_controller and the device-side responder,
// plus the serial line pins and the error pulses.
// The responder uses the slave modport; the controller or bench uses master.
interface uart_bus_responder_if;
    logic       rdn;
    logic       wrn;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       data_ready;
    logic       tbre;
    logic       tsre;
    logic       rxd;
    logic       txd;
    logic       rx_overrun;
    logic       frame_err;

    modport slave (
        input  rdn, wrn, data_in, rxd,
        output data_out, data_oe, data_ready, tbre, tsre, txd, rx_overrun, frame_err
    );

    modport master (
        output rdn, wrn, data_in, rxd,
        input  data_out, data_oe, data_ready, tbre, tsre, txd, rx_overrun, frame_err
    );
endinterface

// File: rtl/uart_bus_responder.sv
// Device side of the board's parallel UART: answers rdn/wrn strobes, holds
// one transmit byte and one receive byte, and runs independent 8N1 TX and RX
// engines on txd/rxd. CLK_DIV is clk cycles per bit; it must be even and >= 4.
module uart_bus_responder #(
    parameter int CLK_DIV = 96
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_bus_responder_if.slave  bus
);

    localparam int              CW        = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    // ------------------------------------------------------------------
    // Strobe registers
    // ------------------------------------------------------------------
    logic rdn_q;
    logic wrn_q;
    logic rd_rise;
    logic wr_rise;

    // Register the bus strobes once so their rising edges can be detected.
    // NOTE: every clocked block uses non-blocking assignments so that all
    // registers sample their inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdn_q <= 1'b1;
            wrn_q <= 1'b1;
        end else begin
            rdn_q <= bus.rdn;
            wrn_q <= bus.wrn;
        end
    end

    assign rd_rise = ~rdn_q & bus.rdn;
    assign wr_rise = ~wrn_q & bus.wrn;

    // ------------------------------------------------------------------
    // Transmit path: holding register feeding the shift FSM
    // ------------------------------------------------------------------
    tx_state_e       tx_state_q;
    logic [CW-1:0]   tx_cnt_q;
    logic [2:0]      tx_bit_q;
    logic [7:0]      tx_shift_q;
    logic [7:0]      hold_q;
    logic            hold_full_q;
    logic            txd_q;
    logic            tsre_q;
    logic            wr_accept;
    logic            tx_bit_end;

    // A write lands only while the holding register is empty and no read is in progress.
    assign wr_accept  = wr_rise & ~hold_full_q & bus.rdn;
    assign tx_bit_end = (tx_cnt_q == BIT_LAST);

    // Holding register and TX FSM; a load and a write can never coincide
    // because one needs the holding register full and the other empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            txd_q       <= 1'b1;
            tsre_q      <= 1'b1;
        end else begin
            if (wr_accept) begin
                hold_q      <= bus.data_in;
                hold_full_q <= 1'b1;
            end

            tx_cnt_q <= tx_bit_end ? '0 : tx_cnt_q + CW'(1);

            case (tx_state_q)
                TX_IDLE: begin
                    tx_cnt_q <= '0;
                    if (hold_full_q) begin
                        tx_shift_q  <= hold_q;
                        hold_full_q <= 1'b0;
                        txd_q       <= 1'b0;
                        tsre_q      <= 1'b0;
                        tx_state_q  <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_bit_q   <= '0;
                        txd_q      <= tx_shift_q[0];
                        tx_state_q <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        if (tx_bit_q == 3'd7) begin
                            txd_q      <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            txd_q      <= tx_shift_q[1];
                            tx_shift_q <= tx_shift_q >> 1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        if (hold_full_q) begin
                            // Back-to-back frame: next start bit follows the stop bit directly.
                            tx_shift_q  <= hold_q;
                            hold_full_q <= 1'b0;
                            txd_q       <= 1'b0;
                            tx_state_q  <= TX_START;
                        end else begin
                            tsre_q     <= 1'b1;
                            tx_state_q <= TX_IDLE;
                        end
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive path: synchronizer, mid-bit sampling FSM, receive buffer
    // ------------------------------------------------------------------
    logic            rxd_s1_q;
    logic            rxd_s2_q;
    logic            rxd_prev_q;
    rx_state_e       rx_state_q;
    logic [CW-1:0]   rx_cnt_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_shift_q;
    logic [7:0]      rx_buf_q;
    logic            data_ready_q;
    logic            rx_overrun_q;
    logic            frame_err_q;

    // Two-flop synchronizer on rxd plus one more stage for falling-edge detection.
    // NOTE: the stages reset to 1 (idle line) so that leaving reset never
    // looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_s1_q   <= bus.rxd;
            rxd_s2_q   <= rxd_s1_q;
            rxd_prev_q <= rxd_s2_q;
        end
    end

    // RX FSM and buffer; a commit on the same edge as a read rise keeps the
    // new byte flagged as unread and is not an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_buf_q     <= '0;
            data_ready_q <= 1'b0;
            rx_overrun_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_overrun_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_cnt_q     <= rx_cnt_q + CW'(1);

            if (rd_rise) begin
                data_ready_q <= 1'b0;
            end

            case (rx_state_q)
                RX_IDLE: begin
                    rx_cnt_q <= '0;
                    if (rxd_prev_q && !rxd_s2_q) begin
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q <= '0;
                        rx_bit_q <= '0;
                        // A start bit that is high again at mid-bit was only a glitch.
                        rx_state_q <= rxd_s2_q ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rxd_s2_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 3'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_IDLE;
                        if (rxd_s2_q) begin
                            rx_buf_q     <= rx_shift_q;
                            data_ready_q <= 1'b1;
                            rx_overrun_q <= data_ready_q & ~rd_rise;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.txd        = txd_q;
    assign bus.tbre       = ~hold_full_q;
    assign bus.tsre       = tsre_q;
    assign bus.data_out   = rx_buf_q;
    assign bus.data_oe    = ~rdn_q;
    assign bus.data_ready = data_ready_q;
    assign bus.rx_overrun = rx_overrun_q;
    assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_bus_responder.sv
// Bench for uart_bus_responder at CLK_DIV=4: directed bus and line stimulus,
// a time-based reference model checked on every falling clock edge, and
// literal expectations at the interesting points of each scenario.
module tb_uart_bus_responder;

    localparam int DIV  = 4;
    localparam int HIST = 8192;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;
    int   edge_cnt = 0;
    int   ovr_seen = 0;
    int   ferr_seen = 0;

    uart_bus_responder_if bus ();

    uart_bus_responder #(.CLK_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Count error pulses as the DUT emits them.
    always @(negedge clk) begin
        if (bus.rx_overrun === 1'b1) ovr_seen++;
        if (bus.frame_err === 1'b1) ferr_seen++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: frames are tracked by the edge index at which they
    // start; line levels follow from elapsed time divided by the bit period.
    // ------------------------------------------------------------------
    int         m_cyc;
    bit         m_hist [0:HIST-1];
    bit         m_rdn_prev, m_wrn_prev;
    bit         m_hold_full;
    logic [7:0] m_hold;
    bit         m_tx_active;
    int         m_tx_load;
    logic [7:0] m_tx_byte;
    bit         m_rx_busy;
    int         m_rx_fall;
    bit         m_ready;
    logic [7:0] m_buf;
    bit         m_ovr, m_ferr;
    bit         exp_txd, exp_tsre;

    function automatic bit hist(input int i);
        if (i < 0 || i >= HIST) return 1'b1;
        return m_hist[i];
    endfunction

    // Serial level of bit slot k of a frame: start, eight data bits LSB first, stop.
    function automatic bit line_bit(input int k, input logic [7:0] b);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    always @(posedge clk) begin : model
        int         e, mid;
        bit         rd_rise, wr_rise, hold_old, busy, commit, ferr;
        logic [7:0] rb;
        if (rst) begin
            m_cyc = 0; m_rdn_prev = 1; m_wrn_prev = 1;
            m_hold_full = 0; m_hold = '0; m_tx_active = 0; m_tx_load = 0; m_tx_byte = '0;
            m_rx_busy = 0; m_rx_fall = 0; m_ready = 0; m_buf = '0; m_ovr = 0; m_ferr = 0;
            exp_txd = 1; exp_tsre = 1;
        end else begin
            e = m_cyc;
            if (e < HIST) m_hist[e] = bus.rxd;
            rd_rise = !m_rdn_prev && bus.rdn;
            wr_rise = !m_wrn_prev && bus.wrn;

            busy     = m_tx_active && (e - m_tx_load < 10 * DIV);
            hold_old = m_hold_full;
            if (hold_old && !busy) begin
                m_tx_active = 1; m_tx_load = e; m_tx_byte = m_hold; m_hold_full = 0;
            end
            if (wr_rise && !hold_old && bus.rdn) begin
                m_hold_full = 1; m_hold = bus.data_in;
            end
            if (m_tx_active && (e - m_tx_load < 10 * DIV)) begin
                exp_txd  = line_bit((e - m_tx_load) / DIV, m_tx_byte);
                exp_tsre = 0;
            end else begin
                exp_txd  = 1;
                exp_tsre = 1;
            end

            // The receiver sees the line two edges late; it samples half a
            // bit after the falling edge and then once per bit period.
            commit = 0; ferr = 0; rb = '0;
            if (!m_rx_busy) begin
                if (hist(e - 3) && !hist(e - 2)) begin
                    m_rx_busy = 1; m_rx_fall = e - 2;
                end
            end else begin
                mid = m_rx_fall + DIV / 2;
                if (e == mid + 2) begin
                    if (hist(mid)) m_rx_busy = 0;
                end else if (e == mid + 9 * DIV + 2) begin
                    for (int k = 0; k < 8; k++) rb[k] = hist(mid + DIV * (k + 1));
                    if (hist(mid + 9 * DIV)) commit = 1; else ferr = 1;
                    m_rx_busy = 0;
                end
            end

            m_ferr = ferr;
            m_ovr  = 0;
            if (commit) begin
                m_ovr = m_ready && !rd_rise;
                m_ready = 1;
                m_buf = rb;
            end else if (rd_rise) begin
                m_ready = 0;
            end

            m_rdn_prev = bus.rdn;
            m_wrn_prev = bus.wrn;
            m_cyc++;
        end
    end

    // Compare every output against the model on every cycle.
    always @(negedge clk) begin
        check("txd",        bus.txd,        exp_txd);
        check("tsre",       bus.tsre,       exp_tsre);
        check("tbre",       bus.tbre,       !m_hold_full);
        check("data_oe",    bus.data_oe,    !m_rdn_prev);
        check("data_out",   bus.data_out,   m_buf);
        check("data_ready", bus.data_ready, m_ready);
        check("rx_overrun", bus.rx_overrun, m_ovr);
        check("frame_err",  bus.frame_err,  m_ferr);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_write(input logic [7:0] b);
        bus.data_in = b;
        bus.wrn = 1'b0;
        tick();
        bus.wrn = 1'b1;
        tick();
    endtask

    task automatic bus_read();
        bus.rdn = 1'b0;
        tick();
        bus.rdn = 1'b1;
        tick();
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        bus.rxd = 1'b0;
        repeat (DIV) tick();
        for (int k = 0; k < 8; k++) begin
            bus.rxd = b[k];
            repeat (DIV) tick();
        end
        bus.rxd = stop;
        repeat (DIV) tick();
        bus.rxd = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_txd"},        bus.txd,        1);
        check({tag, "_tbre"},       bus.tbre,       1);
        check({tag, "_tsre"},       bus.tsre,       1);
        check({tag, "_data_ready"}, bus.data_ready, 0);
        check({tag, "_data_oe"},    bus.data_oe,    0);
        check({tag, "_data_out"},   bus.data_out,   0);
        check({tag, "_rx_overrun"}, bus.rx_overrun, 0);
        check({tag, "_frame_err"},  bus.frame_err,  0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [9:0] pat55;
        int         l_edge, l2, o0, f0;

        rst = 1'b1;
        bus.rdn = 1'b1; bus.wrn = 1'b1; bus.data_in = '0; bus.rxd = 1'b1;
        repeat (3) tick();
        check_reset_values("init");
        rst = 1'b0;
        repeat (4) tick();

        // ---- single frame 0x55 ----
        pat55 = 10'b1010101010;             // slot k at bit k: 0,1,0,1,...,1
        bus_write(8'h55);
        check("w55_tbre_low", bus.tbre, 0);
        check("w55_txd_idle", bus.txd, 1);
        tick();
        check("w55_tbre_back", bus.tbre, 1);
        check("w55_tsre_busy", bus.tsre, 0);
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < DIV; j++) begin
                check($sformatf("w55_bit%0d", i), bus.txd, pat55[i]);
                if (i == 9) check("w55_tsre_in_stop", bus.tsre, 0);
                tick();
            end
        end
        check("w55_tsre_done", bus.tsre, 1);
        check("w55_txd_done", bus.txd, 1);
        repeat (3) tick();

        // ---- back-to-back 0xA5, 0x3C, dropped third write ----
        bus_write(8'hA5);
        l_edge = edge_cnt + 1;
        repeat (10) tick();
        bus_write(8'h3C);
        check("b2b_tbre_full", bus.tbre, 0);
        bus_write(8'hFF);
        while (edge_cnt < l_edge + 10 * DIV - 1) tick();
        check("b2b_tbre_held", bus.tbre, 0);
        check("b2b_a5_stop", bus.txd, 1);
        tick();
        l2 = l_edge + 10 * DIV;
        check("b2b_tbre_freed", bus.tbre, 1);
        check("b2b_3c_start", bus.txd, 0);
        check("b2b_tsre", bus.tsre, 0);
        while (edge_cnt < l2 + DIV) tick();
        check("b2b_3c_d0", bus.txd, 0);
        while (edge_cnt < l2 + 3 * DIV) tick();
        check("b2b_3c_d2", bus.txd, 1);
        while (edge_cnt < l2 + 7 * DIV) tick();
        check("b2b_3c_d6", bus.txd, 0);
        while (edge_cnt < l2 + 10 * DIV) tick();
        check("b2b_third_dropped_tsre", bus.tsre, 1);
        repeat (2 * DIV) tick();
        check("b2b_third_dropped_txd", bus.txd, 1);

        // ---- receive 0x3C while transmitting 0x81 ----
        fork
            send_rx(8'h3C, 1'b1);
            begin
                repeat (5) tick();
                bus_write(8'h81);
            end
        join
        repeat (3) tick();
        check("rx3c_ready", bus.data_ready, 1);
        check("rx3c_model_buf", m_buf, 8'h3C);
        bus.rdn = 1'b0;
        tick();
        check("rx3c_oe", bus.data_oe, 1);
        check("rx3c_data", bus.data_out, 8'h3C);
        bus.rdn = 1'b1;
        tick();
        check("rx3c_cleared", bus.data_ready, 0);
        check("rx3c_oe_off", bus.data_oe, 0);
        repeat (50) tick();

        // ---- overrun and glitch ----
        o0 = ovr_seen;
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        repeat (3) tick();
        check("ovr_pulses", ovr_seen - o0, 1);
        check("ovr_buf", bus.data_out, 8'h22);
        check("ovr_ready", bus.data_ready, 1);
        bus_read();
        bus.rxd = 1'b0;
        tick();
        bus.rxd = 1'b1;
        repeat (20) tick();
        check("glitch_no_ready", bus.data_ready, 0);
        check("glitch_buf_kept", bus.data_out, 8'h22);

        // ---- framing error ----
        f0 = ferr_seen;
        send_rx(8'h7E, 1'b0);
        repeat (3) tick();
        check("ferr_pulses", ferr_seen - f0, 1);
        check("ferr_no_ready", bus.data_ready, 0);
        check("ferr_buf_kept", bus.data_out, 8'h22);

        // ---- read rise on the commit edge of a new byte ----
        send_rx(8'h33, 1'b1);
        repeat (3) tick();
        check("pre_coinc_ready", bus.data_ready, 1);
        o0 = ovr_seen;
        fork
            send_rx(8'h5A, 1'b1);
            begin
                repeat (10 * DIV - 1) tick();
                bus.rdn = 1'b0;
                tick();
                bus.rdn = 1'b1;
                tick();
            end
        join
        check("coinc_ready", bus.data_ready, 1);
        check("coinc_buf", bus.data_out, 8'h5A);
        tick();
        check("coinc_no_overrun", ovr_seen - o0, 0);
        repeat (10) tick();

        // ---- reset in the middle of TX and RX frames ----
        fork
            send_rx(8'hFF, 1'b1);
            begin
                repeat (2) tick();
                bus_write(8'h96);
                repeat (8) tick();
                check("pre_rst_tsre_busy", bus.tsre, 0);
                rst = 1'b1;
                repeat (3) tick();
                check_reset_values("midrst");
                rst = 1'b0;
                tick();
                check("post_rst_txd", bus.txd, 1);
                check("post_rst_tsre", bus.tsre, 1);
            end
        join
        repeat (20) tick();
        check("post_rst_no_ready", bus.data_ready, 0);

        // ---- write while a read is in progress is ignored ----
        bus.rdn = 1'b0;
        tick();
        bus_write(8'h42);
        check("wr_rdlow_tbre", bus.tbre, 1);
        tick();
        check("wr_rdlow_tsre", bus.tsre, 1);
        check("wr_rdlow_txd", bus.txd, 1);
        bus.rdn = 1'b1;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
